// File: rtl/ha_frame_accumulator.sv
// Accumulates half-adder {carry,sum} samples into per-frame totals presented on a valid/ready port.
// Optional build macro HA_FRAME_ACC_SATURATE_EN clamps the total at 2^WIDTH-1 instead of wrapping.
module ha_frame_accumulator #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic             in_sum,
   input  logic             in_carry,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   input  logic             out_ready,
   output logic             err,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             ovf;

   logic             accept, xfer, illegal, last, ovf_next;
   logic [1:0]       val;
   logic [WIDTH-1:0] base, acc_next;
   logic [WIDTH:0]   sum;
   logic [CW-1:0]    cnt_next;

   // Handshake: a beat moves on a rising edge where valid && ready; both ready signals
   // are decoded from registered state only, so neither depends combinationally on its valid.
   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign dbg_state = state;
   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;

   always_comb begin
      illegal  = in_carry && in_sum;
      val      = illegal ? 2'b00 : {in_carry, in_sum};
      // A frame restarts from zero when the first sample lands in IDLE.
      base     = (state == IDLE) ? '0 : acc;
      sum      = {1'b0, base} + {{(WIDTH-1){1'b0}}, val};
      ovf_next = ((state == IDLE) ? 1'b0 : ovf) | sum[WIDTH];
`ifdef HA_FRAME_ACC_SATURATE_EN
      acc_next = ovf_next ? '1 : sum[WIDTH-1:0];
`else
      acc_next = sum[WIDTH-1:0];
`endif
      cnt_next = (state == IDLE) ? CW'(1) : cnt + CW'(1);
      last     = (cnt_next == LAST);
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, ACCUM: begin
            if (accept) state_next = last ? HOLD : ACCUM;
         end
         HOLD: begin
            if (xfer) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         acc      <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         out_data <= '0;
         out_ovf  <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            ovf <= ovf_next;
            if (illegal) err <= 1'b1;
            if (last) begin
               out_data <= acc_next;
               out_ovf  <= ovf_next;
            end
         end else if (xfer) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ha_frame_accumulator.sv
// Bench for ha_frame_accumulator: four parameterisations share stimulus pins, one selected at a time.
module tb_ha_frame_accumulator;

   localparam int NI = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic in_sum = 1'b0, in_carry = 1'b0, out_ready = 1'b0, in_valid = 1'b0;
   int   sel = 0;

   logic [NI-1:0] iv, rdy, vld, ovf, er;
   logic [7:0]    d0, d2, d3;
   logic [2:0]    d1;
   logic [1:0]    st0, st1, st2, st3;

   logic       obs_ready, obs_valid, obs_ovf, obs_err;
   logic [7:0] obs_data;

   logic [8:0] exp_q[$];
   int         mdl_total = 0, mdl_cnt = 0;
   bit         mdl_err[NI];
   int         n_checks = 0, n_errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      iv        = '0;
      iv[sel]   = in_valid;
      obs_ready = rdy[sel];
      obs_valid = vld[sel];
      obs_ovf   = ovf[sel];
      obs_err   = er[sel];
      case (sel)
         0:       obs_data = d0;
         1:       obs_data = {5'b0, d1};
         2:       obs_data = d2;
         default: obs_data = d3;
      endcase
   end

   ha_frame_accumulator #(.WIDTH(8), .FRAME_LEN(4)) dut_a (
      .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_sum(in_sum), .in_carry(in_carry),
      .in_ready(rdy[0]), .out_valid(vld[0]), .out_data(d0), .out_ovf(ovf[0]),
      .out_ready(out_ready), .err(er[0]), .dbg_state(st0));
   ha_frame_accumulator #(.WIDTH(3), .FRAME_LEN(4)) dut_b (
      .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_sum(in_sum), .in_carry(in_carry),
      .in_ready(rdy[1]), .out_valid(vld[1]), .out_data(d1), .out_ovf(ovf[1]),
      .out_ready(out_ready), .err(er[1]), .dbg_state(st1));
   ha_frame_accumulator #(.WIDTH(8), .FRAME_LEN(2)) dut_c (
      .clk(clk), .rstn(rstn), .in_valid(iv[2]), .in_sum(in_sum), .in_carry(in_carry),
      .in_ready(rdy[2]), .out_valid(vld[2]), .out_data(d2), .out_ovf(ovf[2]),
      .out_ready(out_ready), .err(er[2]), .dbg_state(st2));
   ha_frame_accumulator #(.WIDTH(8), .FRAME_LEN(1)) dut_d (
      .clk(clk), .rstn(rstn), .in_valid(iv[3]), .in_sum(in_sum), .in_carry(in_carry),
      .in_ready(rdy[3]), .out_valid(vld[3]), .out_data(d3), .out_ovf(ovf[3]),
      .out_ready(out_ready), .err(er[3]), .dbg_state(st3));

   function automatic int w_of(input int s);
      return (s == 1) ? 3 : 8;
   endfunction

   function automatic int fl_of(input int s);
      case (s)
         0, 1:    return 4;
         2:       return 2;
         default: return 1;
      endcase
   endfunction

   task automatic model_clear();
      mdl_total = 0;
      mdl_cnt   = 0;
      exp_q.delete();
      for (int i = 0; i < NI; i++) mdl_err[i] = 1'b0;
   endtask

   // Reference model uses the unbounded integer total; overflow means it reached 2^W.
   task automatic model_accept(input logic c, input logic s, output bit done);
      int lim, d;
      bit o;
      lim  = 1 << w_of(sel);
      done = 1'b0;
      if (c && s) mdl_err[sel] = 1'b1;
      else mdl_total += 2 * int'(c) + int'(s);
      mdl_cnt++;
      if (mdl_cnt == fl_of(sel)) begin
         o = (mdl_total >= lim);
`ifdef HA_FRAME_ACC_SATURATE_EN
         d = o ? lim - 1 : mdl_total;
`else
         d = mdl_total % lim;
`endif
         exp_q.push_back({o, 8'(d)});
         mdl_total = 0;
         mdl_cnt   = 0;
         done      = 1'b1;
      end
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rstn      = 1'b0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Called at a negedge; leaves in_valid low at the negedge after the accepting edge.
   task automatic send(input logic c, input logic s);
      int t;
      bit done;
      in_carry = c;
      in_sum   = s;
      in_valid = 1'b1;
      t = 0;
      while (!obs_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!obs_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout sel=%0d in_ready=%b required 1", sel, obs_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      model_accept(c, s, done);
      @(negedge clk);
      in_valid = 1'b0;
      if (done) begin
         n_checks++;
         if (obs_valid !== 1'b1 || obs_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL latency sel=%0d out_valid=%b in_ready=%b required 1/0",
                     sel, obs_valid, obs_ready);
         end
      end
   endtask

   task automatic collect(input int hold);
      int t;
      logic [8:0] exp;
      logic [7:0] first;
      t = 0;
      while (!obs_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (!obs_valid || exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL collect sel=%0d out_valid=%b queued=%0d required 1 and >0",
                  sel, obs_valid, exp_q.size());
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         return;
      end
      exp   = exp_q.pop_front();
      first = obs_data;
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs_valid !== 1'b1 || obs_ready !== 1'b0 || obs_data !== first) begin
            n_errors++;
            $display("FAIL hold sel=%0d valid=%b ready=%b data=%0d required 1/0/%0d",
                     sel, obs_valid, obs_ready, obs_data, first);
         end
      end
      n_checks++;
      if (obs_data !== exp[7:0]) begin
         n_errors++;
         $display("FAIL out_data sel=%0d got %0d required %0d", sel, obs_data, exp[7:0]);
      end
      n_checks++;
      if (obs_ovf !== exp[8]) begin
         n_errors++;
         $display("FAIL out_ovf sel=%0d got %b required %b", sel, obs_ovf, exp[8]);
      end
      n_checks++;
      if (obs_err !== mdl_err[sel]) begin
         n_errors++;
         $display("FAIL err sel=%0d got %b required %b", sel, obs_err, mdl_err[sel]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL release sel=%0d out_valid=%b in_ready=%b required 0/1",
                  sel, obs_valid, obs_ready);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      n_checks++;
      if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_data !== 8'd0 ||
          obs_ovf !== 1'b0 || obs_err !== 1'b0) begin
         n_errors++;
         $display("FAIL %s sel=%0d rdy=%b vld=%b data=%0d ovf=%b err=%b required 1/0/0/0/0",
                  tag, sel, obs_ready, obs_valid, obs_data, obs_ovf, obs_err);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      model_clear();
      #2;
      for (int s = 0; s < NI; s++) begin
         sel = s;
         #1;
         check_idle_outputs("reset_state");
      end
      sel = 0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_nominal();
      sel = 0;
      send(1'b0, 1'b1);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b0, 1'b1);
      collect(0);
   endtask

   task automatic test_overflow();
      sel = 1;
      for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
      collect(0);
   endtask

   task automatic test_backpressure();
      sel = 0;
      for (int i = 0; i < 4; i++) send(1'b1, 1'b1 ^ i[0]);
      in_carry = 1'b1;
      in_sum   = 1'b0;
      in_valid = 1'b1;
      collect(5);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) send(1'b0, 1'b1);
      collect(0);
   endtask

   task automatic test_illegal();
      sel = 2;
      send(1'b1, 1'b1);
      send(1'b0, 1'b1);
      collect(0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      collect(1);
      do_reset();
      #1;
      check_idle_outputs("err_cleared");
   endtask

   task automatic test_reset_midframe();
      sel = 0;
      for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
      collect(0);
      send(1'b1, 1'b1);
      send(1'b0, 1'b1);
      n_checks++;
      if (obs_err !== 1'b1) begin
         n_errors++;
         $display("FAIL err_before_reset got %b required 1", obs_err);
      end
      #2;
      rstn = 1'b0;
      model_clear();
      #1;
      check_idle_outputs("async_reset");
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) send(1'b0, 1'b1);
      collect(0);
   endtask

   task automatic test_frame_len_one();
      sel = 3;
      for (int i = 0; i < 4; i++) begin
         send(i[0], ~i[0]);
         collect(0);
      end
   endtask

   task automatic test_back_to_back_random();
      logic c, s;
      for (int f = 0; f < 8; f++) begin
         sel = $urandom_range(0, 2);
         for (int i = 0; i < fl_of(sel); i++) begin
            c = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 9) == 0) ? c : 1'($urandom_range(0, 1)) & ~c;
            send(c, s);
         end
         collect($urandom_range(0, 3));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_nominal();
      test_overflow();
      test_backpressure();
      test_illegal();
      test_reset_midframe();
      test_frame_len_one();
      test_back_to_back_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
